// File: rtl/fp_align_pkg.sv
// Shared widths, state encoding and constants for the operand-alignment path.
// Optional FP_ALIGN_FASTSHIFT_EN selects single-cycle barrel alignment in fp_align_seq.
package fp_align_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned GRS_W  = 3;
  localparam int unsigned MAN_W  = 1 + FRAC_W + GRS_W;
  localparam int unsigned SIG_W  = 1 + FRAC_W;
  localparam int unsigned OP_W   = 1 + EXP_W + FRAC_W;

  localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

  typedef enum logic [1:0] {
    StIdle,
    StCmp,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/fp_rshift_sticky.sv
// Right shift of a mantissa by amt_i with every shifted-out bit ORed into the LSB.
// Amounts at or beyond Width collapse the whole input into the sticky LSB.
module fp_rshift_sticky #(
  parameter int unsigned Width = 27,
  parameter int unsigned AmtW  = 8
) (
  input  logic [Width-1:0] data_i,
  input  logic [AmtW-1:0]  amt_i,
  output logic [Width-1:0] data_o
);

  logic sticky;

  always_comb begin
    sticky = 1'b0;
    for (int unsigned i = 0; i < Width; i++) begin
      if (32'(amt_i) > i) begin
        sticky = sticky | data_i[i];
      end
    end
    data_o    = data_i >> amt_i;
    data_o[0] = data_o[0] | sticky;
  end

endmodule

// File: rtl/fp_align_seq.sv
// Sequential exponent compare / mantissa alignment ahead of the FP adder.
// FP_ALIGN_FASTSHIFT_EN: align in CMP with a barrel shifter instead of iterating in SHIFT.
module fp_align_seq
  import fp_align_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [OP_W-1:0]  a_i,
  input  logic [OP_W-1:0]  b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             swap_o,
  output logic [EXP_W-1:0] exp_out_o,
  output logic [MAN_W-1:0] man_big_o,
  output logic [MAN_W-1:0] man_small_o,
  output logic             sign_big_o,
  output logic             sign_small_o,
  output logic             special_o,
  output logic             busy_o
);

  state_e             state_q, state_d;
  logic [OP_W-1:0]    a_q, a_d, b_q, b_d;
  logic               swap_q, swap_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [MAN_W-1:0]   man_big_q, man_big_d, man_small_q, man_small_d;
  logic               sign_big_q, sign_big_d, sign_small_q, sign_small_d;
  logic               special_q, special_d;
`ifndef FP_ALIGN_FASTSHIFT_EN
  logic [EXP_W-1:0]   cnt_q, cnt_d;
`endif

  // Operand decode of the registered pair
  logic [EXP_W-1:0] exp_a, exp_b, eff_a, eff_b, eff_big, eff_small, diff_c;
  logic [SIG_W-1:0] sig_a, sig_b, sig_big, sig_small;
  logic             swap_c;
  logic [MAN_W-1:0] raw_small, shift_in, shift_out;

  always_comb begin
    exp_a     = a_q[OP_W-2 -: EXP_W];
    exp_b     = b_q[OP_W-2 -: EXP_W];
    eff_a     = (exp_a == '0) ? EXP_W'(1) : exp_a;
    eff_b     = (exp_b == '0) ? EXP_W'(1) : exp_b;
    sig_a     = {(exp_a != '0), a_q[FRAC_W-1:0]};
    sig_b     = {(exp_b != '0), b_q[FRAC_W-1:0]};
    swap_c    = (eff_b > eff_a) || ((eff_b == eff_a) && (sig_b > sig_a));
    eff_big   = swap_c ? eff_b : eff_a;
    eff_small = swap_c ? eff_a : eff_b;
    sig_big   = swap_c ? sig_b : sig_a;
    sig_small = swap_c ? sig_a : sig_b;
    diff_c    = eff_big - eff_small;
    raw_small = {sig_small, {GRS_W{1'b0}}};
  end

`ifdef FP_ALIGN_FASTSHIFT_EN
  assign shift_in = raw_small;
  fp_rshift_sticky #(
    .Width (MAN_W),
    .AmtW  (EXP_W)
  ) u_rshift (
    .data_i (shift_in),
    .amt_i  (diff_c),
    .data_o (shift_out)
  );
`else
  assign shift_in = man_small_q;
  fp_rshift_sticky #(
    .Width (MAN_W),
    .AmtW  (EXP_W)
  ) u_rshift (
    .data_i (shift_in),
    .amt_i  (EXP_W'(1)),
    .data_o (shift_out)
  );
`endif

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    swap_d       = swap_q;
    exp_d        = exp_q;
    man_big_d    = man_big_q;
    man_small_d  = man_small_q;
    sign_big_d   = sign_big_q;
    sign_small_d = sign_small_q;
    special_d    = special_q;
`ifndef FP_ALIGN_FASTSHIFT_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          state_d = StCmp;
        end
      end
      StCmp: begin
        swap_d       = swap_c;
        exp_d        = eff_big;
        man_big_d    = {sig_big, {GRS_W{1'b0}}};
        sign_big_d   = swap_c ? b_q[OP_W-1] : a_q[OP_W-1];
        sign_small_d = swap_c ? a_q[OP_W-1] : b_q[OP_W-1];
        special_d    = (exp_a == EXP_ALL_ONES) || (exp_b == EXP_ALL_ONES);
`ifdef FP_ALIGN_FASTSHIFT_EN
        man_small_d  = shift_out;
        state_d      = StDone;
`else
        if (diff_c == '0) begin
          man_small_d = raw_small;
          state_d     = StDone;
        end else if (diff_c >= EXP_W'(MAN_W)) begin
          man_small_d = {{(MAN_W-1){1'b0}}, |raw_small};
          state_d     = StDone;
        end else begin
          man_small_d = raw_small;
          cnt_d       = diff_c;
          state_d     = StShift;
        end
`endif
      end
`ifndef FP_ALIGN_FASTSHIFT_EN
      StShift: begin
        man_small_d = shift_out;
        cnt_d       = cnt_q - EXP_W'(1);
        if (cnt_q == EXP_W'(1)) begin
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      swap_q       <= 1'b0;
      exp_q        <= '0;
      man_big_q    <= '0;
      man_small_q  <= '0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      special_q    <= 1'b0;
`ifndef FP_ALIGN_FASTSHIFT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      swap_q       <= swap_d;
      exp_q        <= exp_d;
      man_big_q    <= man_big_d;
      man_small_q  <= man_small_d;
      sign_big_q   <= sign_big_d;
      sign_small_q <= sign_small_d;
      special_q    <= special_d;
`ifndef FP_ALIGN_FASTSHIFT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  // swap/exp_out are shown combinationally during CMP so the muxes can steer immediately
  assign swap_o       = (state_q == StCmp) ? swap_c : swap_q;
  assign exp_out_o    = (state_q == StCmp) ? eff_big : exp_q;
  assign man_big_o    = man_big_q;
  assign man_small_o  = man_small_q;
  assign sign_big_o   = sign_big_q;
  assign sign_small_o = sign_small_q;
  assign special_o    = special_q;
  assign in_ready_o   = (state_q == StIdle);
  assign out_valid_o  = (state_q == StDone);
  assign busy_o       = (state_q != StIdle);

endmodule
